// File: rtl/clock_select_ctrl.sv
// clock_select_ctrl: issues one select strobe per accepted switch, tracks OUT_RST assert/release, then dwells.
// Define CLKSEL_CTRL_TIMEOUT_EN to compile in the wait-state watchdog and sticky TIMEOUT_ERR.
module clock_select_ctrl #(
   parameter int unsigned DWELL   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic REQ_VALID,
   input  logic REQ_SEL,
   output logic REQ_READY,
   output logic SELECT,
   output logic SELECT_ENABLE,
   input  logic SEL_RST_N,
   output logic CUR_SEL,
   output logic BUSY,
   output logic TIMEOUT_ERR,
   input  logic ERR_CLR
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ASSERT, WAIT_RELEASE, DWELL_ST} state_t;
   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   state_t state, state_n;
   logic [1:0] sync;
   logic [7:0] dcnt;
   logic alive, target, accept, wd_fire;
   assign REQ_READY = alive && state == IDLE;
   assign BUSY = state != IDLE;
   assign accept = REQ_VALID && REQ_READY;
   // A progressing wait state always wins over a watchdog expiry on the same cycle.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:         state_n = accept && REQ_SEL != CUR_SEL ? ISSUE : IDLE;
         ISSUE:        state_n = WAIT_ASSERT;
         WAIT_ASSERT:  state_n = !sync[1] ? WAIT_RELEASE : wd_fire ? IDLE : WAIT_ASSERT;
         WAIT_RELEASE: state_n = sync[1] ? DWELL_ST : wd_fire ? IDLE : WAIT_RELEASE;
         DWELL_ST:     state_n = dcnt == DWELL_LAST ? IDLE : DWELL_ST;
         default:      state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= IDLE;
         sync <= 2'b00;
         dcnt <= 8'd0;
         alive <= 1'b0;
         target <= 1'b0;
         SELECT <= 1'b0;
         SELECT_ENABLE <= 1'b0;
         CUR_SEL <= 1'b0;
      end else begin
         state <= state_n;
         sync <= {sync[0], SEL_RST_N};
         dcnt <= state == DWELL_ST && state_n == DWELL_ST ? dcnt + {7'd0, ~&dcnt} : 8'd0;
         alive <= 1'b1;
         target <= accept ? REQ_SEL : target;
         SELECT <= state_n == ISSUE ? REQ_SEL : SELECT;
         SELECT_ENABLE <= state_n == ISSUE;
         CUR_SEL <= BUSY && state_n == IDLE ? target : CUR_SEL;
      end
`ifdef CLKSEL_CTRL_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
   logic [15:0] wd;
   logic waiting;
   assign waiting = state == WAIT_ASSERT || state == WAIT_RELEASE;
   assign wd_fire = wd == TIMEOUT_LAST;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         wd <= 16'd0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         wd <= waiting && state_n == state ? wd + {15'd0, ~&wd} : 16'd0;
         TIMEOUT_ERR <= (waiting && state_n == IDLE) || (TIMEOUT_ERR && !ERR_CLR);
      end
`else
   logic unused_cfg;
   assign wd_fire = 1'b0;
   assign TIMEOUT_ERR = 1'b0;
   assign unused_cfg = ^{ERR_CLR, TIMEOUT[0]};
`endif
endmodule

// File: tb/tb_clock_select_ctrl.sv
// tb_clock_select_ctrl: transaction-level model of the switch sequence, directed test-plan scenarios, random traffic.
module tb_clock_select_ctrl;
   localparam int DW = 4, TO = 10;
   logic CLK = 1'b0, RST = 1'b1, REQ_VALID = 1'b0, REQ_SEL = 1'b0, SEL_RST_N = 1'b1, ERR_CLR = 1'b0;
   logic REQ_READY, SELECT, SELECT_ENABLE, CUR_SEL, BUSY, TIMEOUT_ERR;
   int checks = 0, failures = 0, strobes = 0, busy_cy = 0, lo_wait = 0, lo_len = 0;
   int ph, left, waited;
   bit m_up, m_sel, m_cur, m_tgt, m_err;
   bit [1:0] hist;

   always #5 CLK = ~CLK;

   clock_select_ctrl #(.DWELL(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_SEL(REQ_SEL), .REQ_READY(REQ_READY),
      .SELECT(SELECT), .SELECT_ENABLE(SELECT_ENABLE), .SEL_RST_N(SEL_RST_N), .CUR_SEL(CUR_SEL),
      .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR));

   // ph: 0 idle, 1 strobe cycle, 2 awaiting reset assert, 3 awaiting release, 4 dwelling
   task automatic model_reset;
      ph = 0; left = 0; waited = 0;
      m_up = 0; m_sel = 0; m_cur = 0; m_tgt = 0; m_err = 0; hist = 2'b00;
   endtask

   function automatic bit timed_out;
      waited++;
`ifdef CLKSEL_CTRL_TIMEOUT_EN
      return waited == TO;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step;
      bit seen, fire;
      seen = hist[1];
      fire = 0;
      case (ph)
         0: if (m_up && REQ_VALID && REQ_SEL != m_cur) begin ph = 1; m_tgt = REQ_SEL; m_sel = REQ_SEL; end
         1: begin ph = 2; waited = 0; end
         2: if (!seen) begin ph = 3; waited = 0; end else fire = timed_out();
         3: if (seen) begin ph = 4; left = DW; end else fire = timed_out();
         default: begin left--; if (left == 0) begin ph = 0; m_cur = m_tgt; end end
      endcase
      if (fire) begin ph = 0; m_cur = m_tgt; end
`ifdef CLKSEL_CTRL_TIMEOUT_EN
      m_err = fire || (m_err && !ERR_CLR);
`endif
      hist = {hist[0], SEL_RST_N};
      m_up = 1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare;
      chk("REQ_READY", int'(REQ_READY === 1'b1), int'(m_up && ph == 0));
      chk("SELECT", int'(SELECT === 1'b1), int'(m_sel));
      chk("SELECT_ENABLE", int'(SELECT_ENABLE === 1'b1), int'(ph == 1));
      chk("CUR_SEL", int'(CUR_SEL === 1'b1), int'(m_cur));
      chk("BUSY", int'(BUSY === 1'b1), int'(ph != 0));
      chk("TIMEOUT_ERR", int'(TIMEOUT_ERR === 1'b1), int'(m_err));
   endtask

   task automatic tick(input logic v, input logic s, input logic n, input logic c = 1'b0);
      REQ_VALID = v; REQ_SEL = s; SEL_RST_N = n; ERR_CLR = c;
      model_step();
      @(negedge CLK);
      compare();
      strobes += int'(SELECT_ENABLE);
      busy_cy += int'(BUSY);
   endtask

   // Emulates the select stage: after each expected strobe, OUT_RST dips low after a random delay.
   task automatic auto_tick(input logic v, input logic s, input logic c);
      logic n;
      n = 1'b1;
      if (ph == 1) begin
         lo_wait = ($urandom_range(7) == 0) ? int'($urandom_range(40, 15)) : int'($urandom_range(3));
         lo_len = int'($urandom_range(5, 1));
      end
      if (lo_wait > 0) lo_wait--;
      else if (lo_len > 0) begin n = 1'b0; lo_len--; end
      tick(v, s, n, c);
   endtask

   task automatic pulse_reset;
      RST = 1'b1;
      lo_wait = 0; lo_len = 0;
      #1;
      model_reset();
      compare();
      @(negedge CLK);
      compare();
      RST = 1'b0;
      #1 compare();
   endtask

   initial begin
      model_reset();
      @(negedge CLK);
      compare();
      chk("rst_ready", int'(REQ_READY), 0);
      RST = 1'b0;
      #1 compare();
      repeat (3) tick(0, 0, 1);
      chk("ready_after_rst", int'(REQ_READY), 1);
      // First switch to A: OUT_RST low for 3 cycles after the strobe
      strobes = 0; busy_cy = 0;
      tick(1, 1, 1);
      chk("sw1_strobe_sel", int'(SELECT), 1);
      repeat (3) tick(0, 0, 0);
      for (int i = 0; i < 50 && BUSY; i++) tick(0, 0, 1);
      chk("sw1_strobes", strobes, 1);
      chk("sw1_busy_cycles", busy_cy, 10);
      chk("sw1_cur", int'(CUR_SEL), 1);
      chk("sw1_ready", int'(REQ_READY), 1);
      // Same-select request is a no-op acknowledge
      strobes = 0; busy_cy = 0;
      tick(1, 1, 1);
      repeat (2) tick(0, 0, 1);
      chk("same_strobes", strobes, 0);
      chk("same_busy", busy_cy, 0);
      chk("same_cur", int'(CUR_SEL), 1);
      // REQ_VALID held high with alternating REQ_SEL during a switch
      strobes = 0;
      for (int i = 0; i < 120 && (i == 0 || BUSY); i++) auto_tick(1, logic'(i[0]), 0);
      chk("hold_idle", int'(BUSY), 0);
      chk("hold_strobes", strobes, 1);
      chk("hold_cur", int'(CUR_SEL), 0);
      repeat (2) tick(0, 0, 1);
      // Reset while waiting for release
      tick(1, 1, 1);
      repeat (3) tick(0, 0, 0);
      chk("mid_busy", int'(BUSY), 1);
      pulse_reset();
      chk("mid_rst_cur", int'(CUR_SEL), 0);
      chk("mid_rst_select", int'(SELECT), 0);
      chk("mid_rst_busy", int'(BUSY), 0);
      chk("mid_rst_ready", int'(REQ_READY), 0);
      repeat (3) tick(0, 0, 1);
      strobes = 0; busy_cy = 0;
      tick(1, 0, 1);
      repeat (2) tick(0, 0, 1);
      chk("post_rst_noop_strobes", strobes, 0);
      chk("post_rst_noop_busy", busy_cy, 0);
`ifdef CLKSEL_CTRL_TIMEOUT_EN
      // OUT_RST never asserts: watchdog fires after TO cycles in WAIT_ASSERT
      busy_cy = 0;
      tick(1, 1, 1);
      for (int i = 0; i < 40 && BUSY; i++) tick(0, 0, 1);
      chk("to1_busy_cycles", busy_cy, 11);
      chk("to1_err", int'(TIMEOUT_ERR), 1);
      chk("to1_cur", int'(CUR_SEL), 1);
      tick(0, 0, 1, 1);
      chk("to_clr", int'(TIMEOUT_ERR), 0);
      tick(1, 0, 1);
      repeat (10) tick(0, 0, 1);
      chk("to2_still_busy", int'(BUSY), 1);
      tick(0, 0, 1, 1);
      chk("to2_set_wins", int'(TIMEOUT_ERR), 1);
      chk("to2_idle", int'(BUSY), 0);
      chk("to2_cur", int'(CUR_SEL), 0);
      tick(0, 0, 1, 1);
`else
      // Without the watchdog a stall waits indefinitely and then completes normally
      tick(1, 1, 1);
      for (int i = 0; i < 40; i++) tick(0, 0, 1, logic'(i[2]));
      chk("stall_busy", int'(BUSY), 1);
      chk("stall_err", int'(TIMEOUT_ERR), 0);
      repeat (2) tick(0, 0, 0);
      for (int i = 0; i < 30 && BUSY; i++) tick(0, 0, 1);
      chk("stall_done", int'(BUSY), 0);
      chk("stall_cur", int'(CUR_SEL), 1);
`endif
      // Random traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(399) == 0) pulse_reset();
         else auto_tick(logic'($urandom_range(1)), logic'($urandom_range(1)), logic'($urandom_range(15) == 0));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
